// File: rtl/fetch_stage.sv
// fetch_stage: generates the fetch PC, drives a 1-cycle-latency instruction
// memory and presents {pc_r, inst_r, valid_r} to the register-read stage.
// A one-entry hold buffer keeps the instruction stable across load-use stalls.
// A redirect from execute squashes the instruction currently shown to R.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        keep,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_r,
  output logic [31:0] inst_r,
  output logic        valid_r
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] pc_f, pc_nx;
  logic [31:0] hold_inst, hold_nx;
  logic [31:0] pc_inc;
  logic [31:0] target;
  logic        en_c;

  assign pc_inc = pc_f + 32'd4;
  // Low address bits of a redirect target are forced to zero (word aligned).
  assign target = redirect_pc & ~32'd3;
  // Memory is never enabled while reset is held, even though state reads BOOT.
  assign imem_en = en_c & rst_n;

  // State, fetch PC and hold buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc_f      <= RESET_PC;
      hold_inst <= NOP_INST;
    end else begin
      state     <= state_nx;
      pc_f      <= pc_nx;
      hold_inst <= hold_nx;
    end
  end

  // Next-state and fetch request; redirect overrides everything including keep.
  always_comb begin
    state_nx  = state;
    pc_nx     = pc_f;
    hold_nx   = hold_inst;
    en_c      = 1'b0;
    imem_addr = pc_inc;
    if (redirect) begin
      en_c      = 1'b1;
      imem_addr = target;
      pc_nx     = target;
      state_nx  = RUN;
    end else begin
      case (state)
        BOOT: begin
          en_c      = 1'b1;
          imem_addr = RESET_PC;
          pc_nx     = RESET_PC;
          state_nx  = RUN;
        end
        RUN: begin
          if (keep) begin
            hold_nx  = imem_rdata;
            state_nx = HOLD;
          end else begin
            en_c  = 1'b1;
            pc_nx = pc_inc;
          end
        end
        HOLD: begin
          if (!keep) begin
            en_c     = 1'b1;
            pc_nx    = pc_inc;
            state_nx = RUN;
          end
        end
        default: state_nx = BOOT;
      endcase
    end
  end

  // Outputs to R; only redirect reaches valid_r/inst_r combinationally.
  always_comb begin
    pc_r    = pc_f;
    valid_r = 1'b0;
    inst_r  = NOP_INST;
    case (state)
      RUN: begin
        valid_r = 1'b1;
        inst_r  = imem_rdata;
      end
      HOLD: begin
        valid_r = 1'b1;
        inst_r  = hold_inst;
      end
      default: begin
        valid_r = 1'b0;
        inst_r  = NOP_INST;
      end
    endcase
    if (redirect) begin
      valid_r = 1'b0;
      inst_r  = NOP_INST;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, a hand-written
// asynchronous-reset-in-HOLD sequence, and randomized traffic against a
// sequence-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        keep;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic        valid_r;

  int checks   = 0;
  int failures = 0;

  // Reference model state: whether R holds a real instruction, and its PC.
  bit          m_have;
  logic [31:0] m_pc;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .keep       (keep),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .pc_r       (pc_r),
    .inst_r     (inst_r),
    .valid_r    (valid_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  // Synchronous memory: 1-cycle read latency, garbage when not enabled.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= word_at(imem_addr);
    else         imem_rdata <= $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] e_pc, input logic e_valid,
                              input logic [31:0] e_inst, input logic e_en, input logic [31:0] e_addr);
    check({tag, " valid_r"}, {31'd0, valid_r}, {31'd0, e_valid});
    check({tag, " inst_r"}, inst_r, e_inst);
    check({tag, " pc_r"}, pc_r, e_pc);
    check({tag, " imem_en"}, {31'd0, imem_en}, {31'd0, e_en});
    if (e_en) check({tag, " imem_addr"}, imem_addr, e_addr);
  endtask

  // Drive one cycle of inputs away from the active edge, then let them settle.
  task automatic apply_stimulus(input logic k, input logic r, input logic [31:0] rpc);
    @(negedge clk);
    keep        = k;
    redirect    = r;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    keep        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    repeat (2) @(negedge clk);
    check_output("reset", RESET_PC, 1'b0, NOP_INST, 1'b0, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    m_have = 1'b0;
    m_pc   = RESET_PC;
  endtask

  // One model-checked cycle: R shows the instruction at m_pc unless squashed.
  task automatic model_step(input logic k, input logic r, input logic [31:0] rpc);
    logic [31:0] tgt;
    tgt = {rpc[31:2], 2'b00};
    apply_stimulus(k, r, rpc);
    if (r) begin
      check_output("model redirect", m_pc, 1'b0, NOP_INST, 1'b1, tgt);
      m_have = 1'b1;
      m_pc   = tgt;
    end else if (!m_have) begin
      check_output("model boot", m_pc, 1'b0, NOP_INST, 1'b1, RESET_PC);
      m_have = 1'b1;
      m_pc   = RESET_PC;
    end else begin
      check_output("model run", m_pc, 1'b1, word_at(m_pc), !k, m_pc + 32'd4);
      if (!k) m_pc = m_pc + 32'd4;
    end
  endtask

  typedef struct {
    logic        k;
    logic        r;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] inst;
    logic        en;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // Directed sequence starting from reset release.
    vecs[0]  = '{1'b0, 1'b0, 32'd0, 32'h4000_0000, 1'b0, NOP_INST, 1'b1, 32'h4000_0000};
    vecs[1]  = '{1'b0, 1'b0, 32'd0, 32'h4000_0000, 1'b1, word_at(32'h4000_0000), 1'b1, 32'h4000_0004};
    vecs[2]  = '{1'b0, 1'b0, 32'd0, 32'h4000_0004, 1'b1, word_at(32'h4000_0004), 1'b1, 32'h4000_0008};
    vecs[3]  = '{1'b1, 1'b0, 32'd0, 32'h4000_0008, 1'b1, word_at(32'h4000_0008), 1'b0, 32'd0};
    vecs[4]  = '{1'b1, 1'b0, 32'd0, 32'h4000_0008, 1'b1, word_at(32'h4000_0008), 1'b0, 32'd0};
    vecs[5]  = '{1'b1, 1'b0, 32'd0, 32'h4000_0008, 1'b1, word_at(32'h4000_0008), 1'b0, 32'd0};
    vecs[6]  = '{1'b0, 1'b0, 32'd0, 32'h4000_0008, 1'b1, word_at(32'h4000_0008), 1'b1, 32'h4000_000C};
    vecs[7]  = '{1'b0, 1'b0, 32'd0, 32'h4000_000C, 1'b1, word_at(32'h4000_000C), 1'b1, 32'h4000_0010};
    vecs[8]  = '{1'b0, 1'b1, 32'h4000_0103, 32'h4000_0010, 1'b0, NOP_INST, 1'b1, 32'h4000_0100};
    vecs[9]  = '{1'b1, 1'b0, 32'd0, 32'h4000_0100, 1'b1, word_at(32'h4000_0100), 1'b0, 32'd0};
    vecs[10] = '{1'b1, 1'b1, 32'h4000_0200, 32'h4000_0100, 1'b0, NOP_INST, 1'b1, 32'h4000_0200};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 32'h4000_0200, 1'b0, NOP_INST, 1'b1, 32'hFFFF_FFFC};
    vecs[12] = '{1'b0, 1'b0, 32'd0, 32'hFFFF_FFFC, 1'b1, word_at(32'hFFFF_FFFC), 1'b1, 32'h0000_0000};
    vecs[13] = '{1'b0, 1'b0, 32'd0, 32'h0000_0000, 1'b1, word_at(32'h0000_0000), 1'b1, 32'h0000_0004};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].k, vecs[i].r, vecs[i].rpc);
      check_output($sformatf("vec%0d", i), vecs[i].pc, vecs[i].valid, vecs[i].inst,
                   vecs[i].en, vecs[i].addr);
    end

    // Asynchronous reset between edges while in HOLD.
    do_reset();
    model_step(1'b0, 1'b0, 32'd0);
    model_step(1'b0, 1'b0, 32'd0);
    model_step(1'b1, 1'b0, 32'd0);
    model_step(1'b1, 1'b0, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_output("async reset", RESET_PC, 1'b0, NOP_INST, 1'b0, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    m_have = 1'b0;
    m_pc   = RESET_PC;
    for (int i = 0; i < 4; i++) model_step(1'b0, 1'b0, 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic        k, r;
      logic [31:0] rpc;
      k   = ($urandom_range(0, 2) == 0);
      r   = ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      model_step(k, r, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
